// File: rtl/issue_controller_pkg.sv
// -----------------------------------------------------------------------------
// issue_controller_pkg
// Shared types for the issue stage: instruction kind, divider FSM state and the
// bundled decode information handed around inside the controller.
// No ports (package).
// -----------------------------------------------------------------------------
package issue_controller_pkg;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned LOAD_CNT_W = 4;   // holds MAX_LOADS up to 15

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_MULDIV = 2'd2,
        KIND_NORD   = 2'd3   // store / branch, no destination register
    } issue_kind_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    typedef struct packed {
        issue_kind_t      kind;
        logic             is_div;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } control_info;

    // True when the instruction allocates a destination register.
    function automatic logic has_rd(input control_info c);
        return (c.kind != KIND_NORD);
    endfunction

endpackage

// File: rtl/issue_controller_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Pending-write scoreboard for x1..x31 with a write-first bypassed lookup.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   set_en, set_rd    mark set_rd pending on the next edge (x0 ignored)
//   clr_en, clr_rd    writeback: clear clr_rd on the next edge
//   rd_addr[3]        lookup addresses
//   rd_pend[3]        pending status with the same-cycle writeback bypassed
// -----------------------------------------------------------------------------
module reg_scoreboard
    import issue_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_W-1:0]      set_rd,
    input  logic                  clr_en,
    input  logic [REG_W-1:0]      clr_rd,
    input  logic [2:0][REG_W-1:0] rd_addr,
    output logic [2:0]            rd_pend
);

    // Bit 0 is held at zero so x0 never hazards and indexing stays simple.
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_rd] = 1'b0;
        end
        // Set is applied after clear so a same-cycle set/clear of one register keeps it pending.
        if (set_en) begin
            pending_d[set_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_pend = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            rd_pend[i] = pending_q[rd_addr[i]] & ~(clr_en && (clr_rd == rd_addr[i]));
        end
    end

endmodule

// File: rtl/issue_controller.sv
// -----------------------------------------------------------------------------
// issue_controller
// Decides each cycle whether the decoded instruction issues or the front end
// stalls. Tracks register hazards, outstanding loads and the shared divider.
// Ports:
//   CLK, RSTN                   clock, asynchronous active-low reset
//   DEC_VALID/KIND/IS_DIV       decoded instruction and its class
//   DEC_RS1, DEC_RS2, DEC_RD    register operands (0 = unused)
//   WB_VALID, WB_RD             register writeback
//   LOAD_DONE                   one load response retired
//   DIV_DONE                    divider result ready pulse
//   FLUSH                       redirect, blocks issue this cycle only
//   ISSUE, STALL                issue decision (combinational)
//   DIV_START, DIV_BUSY         divider start pulse / divider occupied
//   STALL_CNT                   saturating count of stall cycles
// -----------------------------------------------------------------------------
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int unsigned MAX_LOADS = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             DEC_VALID,
    input  issue_kind_t      DEC_KIND,
    input  logic             DEC_IS_DIV,
    input  logic [REG_W-1:0] DEC_RS1,
    input  logic [REG_W-1:0] DEC_RS2,
    input  logic [REG_W-1:0] DEC_RD,
    input  logic             WB_VALID,
    input  logic [REG_W-1:0] WB_RD,
    input  logic             LOAD_DONE,
    input  logic             DIV_DONE,
    input  logic             FLUSH,
    output logic             ISSUE,
    output logic             STALL,
    output logic             DIV_START,
    output logic             DIV_BUSY,
    output logic [CNT_W-1:0] STALL_CNT
);

    control_info            dec;
    logic [2:0][REG_W-1:0]  lookup_addr;
    logic [2:0]             lookup_pend;
    logic                   raw_hz;
    logic                   waw_hz;
    logic                   load_hz;
    logic                   div_hz;
    logic                   issue;
    logic                   sb_set_en;

    logic [LOAD_CNT_W-1:0]  load_cnt_q;
    logic [LOAD_CNT_W-1:0]  load_cnt_d;
    div_state_t             div_state_q;
    div_state_t             div_state_d;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       stall_cnt_d;

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec.kind       = DEC_KIND;
        dec.is_div     = DEC_IS_DIV;
        dec.rs1        = DEC_RS1;
        dec.rs2        = DEC_RS2;
        dec.rd         = DEC_RD;
        lookup_addr[0] = dec.rs1;
        lookup_addr[1] = dec.rs2;
        lookup_addr[2] = dec.rd;
    end

    reg_scoreboard u_sb (
        .clk     (CLK),
        .rst_n   (RSTN),
        .set_en  (sb_set_en),
        .set_rd  (dec.rd),
        .clr_en  (WB_VALID),
        .clr_rd  (WB_RD),
        .rd_addr (lookup_addr),
        .rd_pend (lookup_pend)
    );

    // --------------------------------------------------------------- hazards
    always_comb begin
        raw_hz    = lookup_pend[0] | lookup_pend[1];
        waw_hz    = lookup_pend[2] & has_rd(dec);
        // A retiring load frees its slot in the same cycle.
        load_hz   = (dec.kind == KIND_LOAD)
                  && (load_cnt_q == LOAD_CNT_W'(MAX_LOADS))
                  && !LOAD_DONE;
        div_hz    = dec.is_div && (div_state_q != DIV_IDLE);
        issue     = DEC_VALID & ~FLUSH & ~raw_hz & ~waw_hz & ~load_hz & ~div_hz;
        sb_set_en = issue & has_rd(dec);
    end

    assign ISSUE     = issue;
    assign STALL     = DEC_VALID & ~issue;
    assign DIV_START = issue & dec.is_div;

    // ---------------------------------------------------------- load counter
    always_comb begin
        logic inc;
        logic dec_ok;
        inc    = issue && (dec.kind == KIND_LOAD);
        dec_ok = LOAD_DONE && (load_cnt_q != '0);
        load_cnt_d = load_cnt_q;
        if (inc && !dec_ok) begin
            load_cnt_d = load_cnt_q + 1'b1;
        end else if (!inc && dec_ok) begin
            load_cnt_d = load_cnt_q - 1'b1;
        end
    end

    // ----------------------------------------------------------- divider FSM
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            div_state_q <= DIV_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        unique case (div_state_q)
            DIV_IDLE: if (DIV_START) div_state_d = DIV_RUN;
            DIV_RUN:  if (DIV_DONE)  div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        DIV_BUSY = (div_state_q != DIV_IDLE);
    end

    // --------------------------------------------------------- stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (STALL && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign STALL_CNT = stall_cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            load_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_controller.sv
module tb_issue_controller;
    import issue_controller_pkg::*;

    localparam int unsigned TB_CNT_W = 4;

    logic                CLK;
    logic                RSTN;
    logic                DEC_VALID;
    issue_kind_t         DEC_KIND;
    logic                DEC_IS_DIV;
    logic [4:0]          DEC_RS1, DEC_RS2, DEC_RD;
    logic                WB_VALID;
    logic [4:0]          WB_RD;
    logic                LOAD_DONE, DIV_DONE, FLUSH;
    logic                ISSUE, STALL, DIV_START, DIV_BUSY;
    logic [TB_CNT_W-1:0] STALL_CNT;

    issue_controller #(.MAX_LOADS(4), .CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RSTN(RSTN), .DEC_VALID(DEC_VALID), .DEC_KIND(DEC_KIND),
        .DEC_IS_DIV(DEC_IS_DIV), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .LOAD_DONE(LOAD_DONE), .DIV_DONE(DIV_DONE),
        .FLUSH(FLUSH), .ISSUE(ISSUE), .STALL(STALL), .DIV_START(DIV_START),
        .DIV_BUSY(DIV_BUSY), .STALL_CNT(STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected {ISSUE, STALL, DIV_START, DIV_BUSY} per driven cycle.
    typedef struct {
        string      name;
        logic [3:0] v;
    } exp_t;

    exp_t                exp_q[$];
    int                  checks = 0;
    int                  passes = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;

    function automatic logic [3:0] outs();
        return {ISSUE, STALL, DIV_START, DIV_BUSY};
    endfunction

    task automatic drv_dec(input logic v, input issue_kind_t k, input logic d,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        DEC_VALID = v; DEC_KIND = k; DEC_IS_DIV = d;
        DEC_RS1 = r1; DEC_RS2 = r2; DEC_RD = rd;
    endtask

    task automatic drv_aux(input logic wv, input logic [4:0] wr, input logic ld,
                           input logic dd, input logic fl);
        WB_VALID = wv; WB_RD = wr; LOAD_DONE = ld; DIV_DONE = dd; FLUSH = fl;
    endtask

    task automatic drv_idle();
        drv_dec(1'b0, KIND_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
        drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Stall counter model: advanced once per driven cycle that expects STALL.
    task automatic model_cnt(input logic stalled);
        if (stalled && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        drv_idle();
        @(negedge CLK);
        RSTN = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        RSTN = 1'b0;
        drv_idle();
        exp_q.push_back('{name:"reset_outs", v:4'b0000});
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
        else passes++;
        checks++;
        if (STALL_CNT !== 4'd0) $display("FAIL reset_cnt: STALL_CNT=%0d expected=0", STALL_CNT);
        else passes++;
        // Issue is combinational even while held in reset.
        drv_dec(1'b1, KIND_ALU, 1'b0, 5'd1, 5'd2, 5'd3);
        exp_q.push_back('{name:"reset_comb_issue", v:4'b1000});
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
        else passes++;
        apply_reset();
    endtask

    task automatic test_raw_waw();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 7; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            case (s)
                0: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd5); exp_q.push_back('{name:"raw_producer",  v:4'b1000}); end
                1: begin drv_dec(1, KIND_ALU, 0, 5'd5, 5'd0, 5'd6); exp_q.push_back('{name:"raw_stall",     v:4'b0100}); end
                2: begin drv_dec(1, KIND_ALU, 0, 5'd5, 5'd0, 5'd6); WB_VALID = 1; WB_RD = 5'd5;
                         exp_q.push_back('{name:"raw_wb_bypass", v:4'b1000}); end
                3: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd6, 5'd7); exp_q.push_back('{name:"raw_rs2",       v:4'b0100}); end
                4: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd6); exp_q.push_back('{name:"waw_stall",     v:4'b0100}); end
                5: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd6); WB_VALID = 1; WB_RD = 5'd6;
                         exp_q.push_back('{name:"waw_wb_bypass", v:4'b1000}); end
                default: begin drv_dec(1, KIND_ALU, 0, 5'd6, 5'd0, 5'd0); exp_q.push_back('{name:"set_wins",  v:4'b0100}); end
            endcase
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
        @(negedge CLK); drv_idle(); #1;
        checks++;
        if (STALL_CNT !== exp_cnt) $display("FAIL raw_cnt: STALL_CNT=%0d expected=%0d", STALL_CNT, exp_cnt);
        else passes++;
    endtask

    task automatic test_x0_nord();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            case (s)
                0: begin drv_dec(1, KIND_ALU,  0, 5'd0, 5'd0, 5'd0); exp_q.push_back('{name:"x0_write", v:4'b1000}); end
                1: begin drv_dec(1, KIND_ALU,  0, 5'd0, 5'd0, 5'd0); exp_q.push_back('{name:"x0_read",  v:4'b1000}); end
                2: begin drv_dec(1, KIND_NORD, 0, 5'd1, 5'd2, 5'd9); exp_q.push_back('{name:"nord",     v:4'b1000}); end
                default: begin drv_dec(1, KIND_ALU, 0, 5'd9, 5'd0, 5'd9); exp_q.push_back('{name:"nord_no_pend", v:4'b1000}); end
            endcase
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
    endtask

    task automatic test_loads();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 9; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            drv_dec(1, KIND_LOAD, 0, 5'd0, 5'd0, 5'd0);
            if (s < 4)       exp_q.push_back('{name:"load_fill",     v:4'b1000});
            else if (s == 4) exp_q.push_back('{name:"load_full",     v:4'b0100});
            else if (s == 5) begin LOAD_DONE = 1; exp_q.push_back('{name:"load_done_byp", v:4'b1000}); end
            else if (s == 6) exp_q.push_back('{name:"load_cnt_held", v:4'b0100});
            else if (s == 7) begin DEC_VALID = 0; LOAD_DONE = 1; exp_q.push_back('{name:"load_retire", v:4'b0000}); end
            else             exp_q.push_back('{name:"load_after_ret", v:4'b1000});
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
        // Retire with nothing outstanding must not wrap the counter.
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            if (s == 0) begin
                drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); LOAD_DONE = 1;
                exp_q.push_back('{name:"load_underflow", v:4'b0000});
            end else begin
                drv_dec(1, KIND_LOAD, 0, 5'd0, 5'd0, 5'd0);
                exp_q.push_back('{name:"load_post_uflow", v:(s < 5) ? 4'b1000 : 4'b0100});
            end
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
    endtask

    task automatic test_divider();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 8; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            case (s)
                0: begin drv_dec(1, KIND_MULDIV, 1, 5'd0, 5'd0, 5'd20); exp_q.push_back('{name:"div_start",  v:4'b1010}); end
                1: begin drv_dec(1, KIND_MULDIV, 1, 5'd0, 5'd0, 5'd21); exp_q.push_back('{name:"div_busy",   v:4'b0101}); end
                2: begin drv_dec(1, KIND_MULDIV, 1, 5'd0, 5'd0, 5'd21); DIV_DONE = 1;
                         exp_q.push_back('{name:"div_done_cyc", v:4'b0101}); end
                3: begin drv_dec(1, KIND_MULDIV, 1, 5'd0, 5'd0, 5'd21); exp_q.push_back('{name:"div_second", v:4'b1010}); end
                4: begin drv_dec(1, KIND_MULDIV, 0, 5'd0, 5'd0, 5'd22); exp_q.push_back('{name:"mul_while_div", v:4'b1001}); end
                5: begin drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); DIV_DONE = 1;
                         exp_q.push_back('{name:"div_done2", v:4'b0001}); end
                6: begin drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); DIV_DONE = 1;
                         exp_q.push_back('{name:"div_done_idle", v:4'b0000}); end
                default: begin drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); exp_q.push_back('{name:"div_stay_idle", v:4'b0000}); end
            endcase
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            case (s)
                0: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd8); FLUSH = 1; exp_q.push_back('{name:"flush_block", v:4'b0100}); end
                1: begin drv_dec(1, KIND_ALU, 0, 5'd8, 5'd0, 5'd9); exp_q.push_back('{name:"flush_no_set", v:4'b1000}); end
                2: begin drv_dec(1, KIND_ALU, 0, 5'd9, 5'd0, 5'd0); FLUSH = 1; exp_q.push_back('{name:"flush_hazard", v:4'b0100}); end
                3: begin drv_dec(1, KIND_ALU, 0, 5'd9, 5'd0, 5'd0); exp_q.push_back('{name:"flush_keeps_pend", v:4'b0100}); end
                default: begin drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); FLUSH = 1; exp_q.push_back('{name:"flush_idle", v:4'b0000}); end
            endcase
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            model_cnt(e.v[2]);
        end
        @(negedge CLK); drv_idle(); #1;
        checks++;
        if (STALL_CNT !== exp_cnt) $display("FAIL flush_cnt: STALL_CNT=%0d expected=%0d", STALL_CNT, exp_cnt);
        else passes++;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int s = 0; s < 20; s++) begin
            @(negedge CLK);
            drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd1);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            model_cnt(1'b1);
        end
        @(negedge CLK); drv_idle(); #1;
        checks++;
        if (STALL_CNT !== exp_cnt || exp_cnt !== 4'hF)
            $display("FAIL cnt_saturate: STALL_CNT=%0d expected=%0d", STALL_CNT, 4'hF);
        else passes++;
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            @(negedge CLK);
            drv_aux(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            case (s)
                0: begin drv_dec(1, KIND_MULDIV, 1, 5'd0, 5'd0, 5'd3); exp_q.push_back('{name:"rmd_div",   v:4'b1010}); end
                1: begin drv_dec(1, KIND_ALU, 0, 5'd0, 5'd0, 5'd4);    exp_q.push_back('{name:"rmd_alu",   v:4'b1001}); end
                2: begin drv_dec(1, KIND_ALU, 0, 5'd3, 5'd0, 5'd0);    exp_q.push_back('{name:"rmd_stall", v:4'b0101}); end
                3: begin drv_idle(); RSTN = 0; exp_q.push_back('{name:"rmd_in_reset", v:4'b0000}); end
                4: begin RSTN = 1; drv_dec(0, KIND_ALU, 0, 5'd0, 5'd0, 5'd0); DIV_DONE = 1;
                         exp_q.push_back('{name:"rmd_stray_done", v:4'b0000}); end
                default: begin drv_dec(1, KIND_MULDIV, 1, 5'd3, 5'd4, 5'd3); exp_q.push_back('{name:"rmd_clean", v:4'b1010}); end
            endcase
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e.v) $display("FAIL %s: outs=%b expected=%b", e.name, outs(), e.v);
            else passes++;
            if (s == 3) begin
                exp_cnt = '0;
                checks++;
                if (STALL_CNT !== exp_cnt) $display("FAIL rmd_cnt: STALL_CNT=%0d expected=0", STALL_CNT);
                else passes++;
            end else begin
                model_cnt(e.v[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw_waw();
        test_x0_nord();
        test_loads();
        test_divider();
        test_flush();
        test_saturate();
        test_reset_mid_div();
        @(negedge CLK);
        drv_idle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
        $fatal(1);
    end

endmodule
